// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter/sequencer: opcodes, controller state
// encoding and opcode classification helpers.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SHL1 = 3'b100;
  localparam logic [2:0] ALU_SHR1 = 3'b101;
  localparam logic [2:0] ALU_NOP  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } alu_ctrl_state_t;

  // 011 doubles as the ALU hold code, so requesters may not issue it; 111 is unused.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op != 3'b011) && (op != 3'b111);
  endfunction

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SHL1) || (op == ALU_SHR1);
  endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past ptr and
// returns the winner as both an index and a one-hot vector.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_oh
);

  int cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!gnt_valid && req[cand]) begin
        gnt_valid    = 1'b1;
        gnt_idx      = PTR_W'(cand);
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one registered ALU among NUM_REQ requesters, sequencing shift-by-N as
// repeated shift-by-1 passes and returning result/flags to the owning requester.
module alu_arbiter_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [3*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [SHAMT_W*NUM_REQ-1:0] req_shamt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_overflow,
  output logic                      rsp_err,
  output logic [2:0]                alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_overflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  alu_ctrl_state_t state, state_nxt;

  logic [PTR_W-1:0]   ptr, id_r, gnt_idx;
  logic               gnt_valid, accept;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [2:0]         op_r, sel_op;
  logic [DATA_W-1:0]  cur_a, b_r, sel_a, sel_b;
  logic [SHAMT_W-1:0] cnt, sel_shamt;
  logic               ovf_acc, err_r;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_oh    (gnt_oh)
  );

  always_comb begin
    sel_op    = ALU_NOP;
    sel_a     = '0;
    sel_b     = '0;
    sel_shamt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_op    = req_op[i*3 +: 3];
        sel_a     = req_a[i*DATA_W +: DATA_W];
        sel_b     = req_b[i*DATA_W +: DATA_W];
        sel_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
      end
    end
  end

  assign accept    = (state == ST_IDLE) && gnt_valid;
  assign req_ready = ((state == ST_IDLE) && !rst) ? gnt_oh : '0;

  // Outside ISSUE the ALU sees NOP so it keeps presenting the last result.
  assign alu_op = (state == ST_ISSUE) ? op_r  : ALU_NOP;
  assign alu_a  = (state == ST_ISSUE) ? cur_a : '0;
  assign alu_b  = (state == ST_ISSUE) ? b_r   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_legal_op(sel_op) || (is_shift_op(sel_op) && (sel_shamt == '0)))
            state_nxt = ST_RESP;
          else
            state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = (cnt == SHAMT_W'(1)) ? ST_RESP : ST_ISSUE;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= PTR_W'(NUM_REQ - 1);
      id_r         <= '0;
      cnt          <= '0;
      ovf_acc      <= 1'b0;
      err_r        <= 1'b0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr     <= gnt_idx;
            id_r    <= gnt_idx;
            ovf_acc <= 1'b0;
            err_r   <= !is_legal_op(sel_op);
            cnt     <= is_shift_op(sel_op) ? sel_shamt : SHAMT_W'(1);
          end
        end
        ST_WAIT: begin
          ovf_acc <= ovf_acc | alu_overflow;
          cnt     <= cnt - 1'b1;
        end
        ST_RESP: begin
          rsp_valid    <= NUM_REQ'(1) << id_r;
          rsp_result   <= cur_a;
          rsp_zero     <= (cur_a == '0);
          rsp_overflow <= ovf_acc;
          rsp_err      <= err_r;
        end
        default: ;
      endcase
    end
  end

  // Operand/result datapath: loaded at accept, refreshed from the ALU each WAIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= sel_op;
      b_r   <= sel_b;
      cur_a <= is_legal_op(sel_op) ? sel_a : '0;
    end else if (state == ST_WAIT) begin
      cur_a <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Self-checking bench for alu_arbiter_ctrl: stand-in registered ALU, directed
// scenarios, then randomized traffic checked against a transaction-level model.
module tb_alu_arbiter_ctrl;
  import alu_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid;
  logic [3*NR-1:0] req_op;
  logic [DW*NR-1:0] req_a, req_b;
  logic [SW*NR-1:0] req_shamt;
  logic [DW-1:0]   rsp_result, alu_a, alu_b, alu_result;
  logic            rsp_zero, rsp_overflow, rsp_err, alu_overflow;
  logic [2:0]      alu_op;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow)
  );

  // {overflow, result} of one ALU pass
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      ALU_AND:  s = {1'b0, a & b};
      ALU_OR:   s = {1'b0, a | b};
      ALU_ADD:  s = {1'b0, a} + {1'b0, b};
      ALU_SUB:  s = {(a < b), a - b};
      ALU_SHL1: s = {a[31], a << 1};
      ALU_SHR1: s = {a[0], a >> 1};
      default:  s = {1'b0, a};
    endcase
    return s;
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB) ||
           (op == ALU_SHL1) || (op == ALU_SHR1);
  endfunction

  always @(posedge clk) begin
    if (legal(alu_op)) {alu_overflow, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z, o, e;
    int          lat;
  } rsp_t;
  rsp_t log_q[$];

  // Transaction-level model state
  int          cyc = 0;
  int          free_at = 0, last_id = NR - 1;
  bit          pend = 0;
  int          p_id, p_acc = 0, p_rsp, p_iters;
  logic [2:0]  p_op;
  logic [31:0] p_b, p_res;
  logic        p_ovf, p_err;
  logic [31:0] p_iter [32];
  bit          acc [NR];
  int          n_shl_issue = 0, n_alu_active = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic predict(input int w);
    logic [2:0]  op;
    logic [31:0] a, v;
    logic [32:0] r;
    int          sh, lat;
    op = req_op[w*3 +: 3];
    a  = req_a[w*DW +: DW];
    sh = int'(req_shamt[w*SW +: SW]);
    p_id = w; p_op = op; p_b = req_b[w*DW +: DW];
    p_ovf = 1'b0; p_err = 1'b0; p_acc = cyc + 1;
    v = a;
    if (!legal(op)) begin
      p_err = 1'b1; p_iters = 0; v = '0;
    end else if (op == ALU_SHL1 || op == ALU_SHR1) p_iters = sh;
    else p_iters = 1;
    for (int i = 0; i < p_iters; i++) begin
      p_iter[i] = v;
      r = alu_fn(op, v, p_b);
      v = r[31:0];
      p_ovf = p_ovf | r[32];
    end
    p_res = v;
    lat = (p_iters == 0) ? 1 : 2 * p_iters + 1;
    p_rsp = cyc + 1 + lat;
    free_at = p_rsp;
    pend = 1;
    last_id = w;
    acc[w] = 1;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_result", rsp_result, '0);
      chk("rst_rsp_zero", rsp_zero, 1'b0);
      chk("rst_rsp_ovf", rsp_overflow, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_alu_op", alu_op, ALU_NOP);
      chk("rst_alu_a", alu_a, '0);
      chk("rst_alu_b", alu_b, '0);
      pend = 0; free_at = 0; last_id = NR - 1;
      for (int r = 0; r < NR; r++) acc[r] = 0;
    end else begin
      if (alu_op != ALU_NOP) n_alu_active++;
      if (rsp_valid != '0) begin
        int id;
        id = -1;
        for (int r = NR - 1; r >= 0; r--) if (rsp_valid[r]) id = r;
        log_q.push_back('{id, rsp_result, rsp_zero, rsp_overflow, rsp_err, cyc - p_acc});
      end
      if (pend && cyc == p_rsp) begin
        chk("rsp_valid", rsp_valid, NR'(1) << p_id);
        chk("rsp_result", rsp_result, p_res);
        chk("rsp_zero", rsp_zero, (p_res == 0));
        chk("rsp_ovf", rsp_overflow, p_ovf);
        chk("rsp_err", rsp_err, p_err);
        pend = 0;
      end else chk("rsp_quiet", rsp_valid, '0);
      if (pend && cyc >= p_acc && cyc < p_acc + 2 * p_iters && ((cyc - p_acc) % 2 == 0)) begin
        chk("alu_op", alu_op, p_op);
        chk("alu_a", alu_a, p_iter[(cyc - p_acc) / 2]);
        chk("alu_b", alu_b, p_b);
        if (p_op == ALU_SHL1 && alu_op == ALU_SHL1) n_shl_issue++;
      end else chk("alu_nop", alu_op, ALU_NOP);
      begin
        logic [NR-1:0] exp_rdy;
        int w;
        exp_rdy = '0; w = -1;
        if (cyc >= free_at) begin
          for (int k = 1; k <= NR; k++)
            if (w < 0 && req_valid[(last_id + k) % NR]) w = (last_id + k) % NR;
          if (w >= 0) exp_rdy[w] = 1'b1;
        end
        chk("req_ready", req_ready, exp_rdy);
        if (w >= 0) predict(w);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) if (acc[r]) begin
      req_valid[r] = 1'b0;
      acc[r] = 0;
    end
  endtask

  task automatic send(input int r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int sh);
    req_op[r*3 +: 3]     = op;
    req_a[r*DW +: DW]    = a;
    req_b[r*DW +: DW]    = b;
    req_shamt[r*SW +: SW] = SW'(sh);
    req_valid[r]         = 1'b1;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((req_valid != '0 || pend) && k < lim) begin
      step();
      k++;
    end
    chk("drain_done", (req_valid != '0) || pend, 1'b0);
  endtask

  task automatic expect_rsp(input string tag, input int id, input int lat, input logic [31:0] res,
                            input logic z, input logic o, input logic e);
    rsp_t t;
    chk({tag, "_present"}, (log_q.size() != 0), 1'b1);
    if (log_q.size() != 0) begin
      t = log_q.pop_front();
      chk({tag, "_id"}, t.id, id);
      chk({tag, "_lat"}, t.lat, lat);
      chk({tag, "_result"}, t.res, res);
      chk({tag, "_zero"}, t.z, z);
      chk({tag, "_ovf"}, t.o, o);
      chk({tag, "_err"}, t.e, e);
    end
  endtask

  task automatic run_random(input int n);
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sh;
    for (int k = 0; k < n; k++) begin
      step();
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom);
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom_range(0, 4) == 0) ? 32'h1 : $urandom);
            if ($urandom_range(0, 3) == 0) sh = ($urandom_range(0, 1) == 1) ? 0 : 31;
            else sh = int'($urandom_range(1, 6));
            send(r, op, a, b, sh);
          end
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    alu_result = '0; alu_overflow = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(0, ALU_SUB, 32'd9, 32'd9, 0);
    send(1, ALU_OR, 32'hF0, 32'h0F, 0);
    step();
    rst = 1'b0;
    drain(100);
    expect_rsp("sub_r0", 0, 3, 32'h0, 1'b1, 1'b0, 1'b0);
    expect_rsp("or_r1", 1, 3, 32'hFF, 1'b0, 1'b0, 1'b0);

    send(0, ALU_ADD, 32'd5, 32'd7, 0);
    drain(100);
    expect_rsp("add", 0, 3, 32'd12, 1'b0, 1'b0, 1'b0);

    n_shl_issue = 0;
    send(1, ALU_SHL1, 32'h1, 32'h0, 4);
    drain(100);
    expect_rsp("shl4", 1, 9, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("shl_issue_count", n_shl_issue, 4);

    send(0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0);
    drain(100);
    expect_rsp("add_wrap", 0, 3, 32'h0, 1'b1, 1'b1, 1'b0);
    send(0, ALU_SHR1, 32'h80, 32'h0, 0);
    drain(100);
    expect_rsp("shr0", 0, 1, 32'h80, 1'b0, 1'b0, 1'b0);

    n_alu_active = 0;
    send(0, 3'b111, 32'h1234, 32'h55, 3);
    drain(100);
    expect_rsp("illegal", 0, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("illegal_alu_idle", n_alu_active, 0);

    send(1, ALU_SHL1, 32'h3, 32'h0, 8);
    k = 0;
    while (!pend && k < 50) begin step(); k++; end
    k = 0;
    while (cyc < p_acc + 3 && k < 50) begin step(); k++; end
    chk("rst_mid_reached_wait", (cyc == p_acc + 3), 1'b1);
    n0 = log_q.size();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("no_rsp_after_rst", log_q.size(), n0);
    send(0, ALU_AND, 32'hF0F0, 32'hFF00, 0);
    send(1, ALU_SHR1, 32'h100, 32'h0, 2);
    drain(100);
    expect_rsp("post_rst_r0", 0, 3, 32'hF000, 1'b0, 1'b0, 1'b0);
    expect_rsp("post_rst_r1", 1, 5, 32'h40, 1'b0, 1'b0, 1'b0);

    run_random(3000);
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
